// File: rtl/imem_arbiter_pkg.sv
// imem_arbiter_pkg: shared types for the instruction memory arbiter
package imem_arbiter_pkg;
  localparam int DATA_W = 32;
  typedef enum logic [1:0] {LOAD, RUN, DRAIN} imem_arb_state_type;
  typedef enum logic {OWN_FETCH, OWN_LOADER} imem_owner_type;
endpackage

// File: rtl/imem_arbiter_starve_counter.sv
// arb_starve_counter: saturating count of consecutive denied loader cycles
module arb_starve_counter #(
  parameter int LIMIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);
  logic [7:0] cnt;
  assign at_limit = cnt >= 8'(LIMIT);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && !at_limit) cnt <= cnt + 8'd1;
endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the instruction SRAM between fetch and the program loader
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int DEPTH_WORDS  = 1024,
  parameter int STARVE_LIMIT = 8,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic              fetch_stall,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [31:0]       ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  input  logic              ld_done,
  input  logic              ld_halt,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              cpu_hold,
  output logic              mem_en,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  imem_arb_state_type state, state_nxt;
  imem_owner_type rd_owner;
  logic fetch_gnt, at_limit, rd_valid;
  logic [DATA_W-1:0] fetch_q, ld_q;
  logic unused;
  assign unused = ^{fetch_addr[31:AW+2], fetch_addr[1:0], ld_addr[31:AW+2], ld_addr[1:0]};
  always_comb begin
    state_nxt = state;
    fetch_gnt = 1'b0;
    ld_gnt = 1'b0;
    fetch_stall = 1'b1;
    case (state)
      LOAD: begin
        ld_gnt = ld_req;
        state_nxt = ld_done ? RUN : LOAD;
      end
      RUN:
        if (ld_halt) state_nxt = DRAIN;
        else begin
          fetch_gnt = fetch_req && !at_limit;
          ld_gnt = ld_req && !fetch_gnt;
          fetch_stall = fetch_req && !fetch_gnt;
        end
      DRAIN: state_nxt = rd_valid ? DRAIN : LOAD;
      default: state_nxt = LOAD;
    endcase
  end
  assign cpu_hold = state == LOAD;
  assign mem_en = fetch_gnt || ld_gnt;
  assign mem_we = ld_gnt && ld_we;
  assign mem_addr = ld_gnt ? ld_addr[AW+1:2] : fetch_gnt ? fetch_addr[AW+1:2] : '0;
  assign mem_wdata = ld_gnt ? ld_wdata : '0;
  // read data is routed by the owner tag captured at grant time
  assign fetch_valid = rd_valid && rd_owner == OWN_FETCH;
  assign ld_rvalid = rd_valid && rd_owner == OWN_LOADER;
  assign fetch_data = fetch_valid ? mem_rdata : fetch_q;
  assign ld_rdata = ld_rvalid ? mem_rdata : ld_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= LOAD;
      rd_valid <= 1'b0;
      rd_owner <= OWN_FETCH;
      fetch_q <= '0;
      ld_q <= '0;
    end else begin
      state <= state_nxt;
      rd_valid <= mem_en && !mem_we;
      rd_owner <= ld_gnt ? OWN_LOADER : OWN_FETCH;
      fetch_q <= fetch_data;
      ld_q <= ld_rdata;
    end
  arb_starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk(clk),
    .reset(reset),
    .inc(ld_req && !ld_gnt),
    .clr(ld_gnt),
    .at_limit(at_limit)
  );
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed vectors plus a cycle-by-cycle reference model
module tb_imem_arbiter;
  localparam int LIM = 8;
  localparam int DW = 1024;
  logic clk = 1'b0;
  logic reset;
  logic fetch_req, ld_req, ld_we, ld_done, ld_halt;
  logic [31:0] fetch_addr, ld_addr, ld_wdata;
  logic fetch_stall, fetch_valid, ld_gnt, ld_rvalid, cpu_hold, mem_en, mem_we;
  logic [31:0] fetch_data, ld_rdata, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [9:0] mem_addr;
  logic [31:0] sram [DW];
  int nvec = 0, nerr = 0;
  int m_mode, m_starve;
  logic m_fv, m_lv;
  logic [31:0] m_fd, m_ld;
  typedef struct packed {logic fg, lg, stall;} grant_t;

  imem_arbiter #(.DEPTH_WORDS(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_stall(fetch_stall),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_done(ld_done), .ld_halt(ld_halt), .ld_gnt(ld_gnt),
    .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata), .cpu_hold(cpu_hold),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else mem_rdata <= sram[mem_addr];
    end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // mode: 0 load, 1 run, 2 drain
  function automatic grant_t grants();
    grant_t g;
    g = '0;
    g.stall = 1'b1;
    if (m_mode == 0) g.lg = ld_req;
    else if (m_mode == 1 && !ld_halt) begin
      g.fg = fetch_req && m_starve < LIM;
      g.lg = ld_req && !g.fg;
      g.stall = fetch_req && !g.fg;
    end
    return g;
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a / 4) % DW);
  endfunction

  always @(posedge clk or posedge reset)
    if (reset) begin
      m_mode <= 0;
      m_starve <= 0;
      m_fv <= 1'b0;
      m_lv <= 1'b0;
      m_fd <= '0;
      m_ld <= '0;
    end else begin
      if (m_mode == 0 && ld_done) m_mode <= 1;
      if (m_mode == 1 && ld_halt) m_mode <= 2;
      if (m_mode == 2 && !m_fv && !m_lv) m_mode <= 0;
      m_starve <= grants().lg ? 0 : (ld_req && m_starve < LIM) ? m_starve + 1 : m_starve;
      m_fv <= grants().fg;
      if (grants().fg) m_fd <= sram[word_of(fetch_addr)];
      m_lv <= grants().lg && !ld_we;
      if (grants().lg && !ld_we) m_ld <= sram[word_of(ld_addr)];
    end

  always @(negedge clk) begin
    check("cpu_hold", cpu_hold, m_mode == 0);
    check("fetch_stall", fetch_stall, grants().stall);
    check("ld_gnt", ld_gnt, grants().lg);
    check("mem_en", mem_en, grants().fg || grants().lg);
    if (mem_en) begin
      check("mem_we", mem_we, grants().lg && ld_we);
      check("mem_addr", mem_addr, word_of(grants().lg ? ld_addr : fetch_addr));
      if (mem_we) check("mem_wdata", mem_wdata, ld_wdata);
    end
    check("fetch_valid", fetch_valid, m_fv);
    check("fetch_data", fetch_data, m_fd);
    check("ld_rvalid", ld_rvalid, m_lv);
    check("ld_rdata", ld_rdata, m_ld);
  end

  task automatic set_in(input logic fr, input logic [31:0] fa, input logic lr, input logic lwe,
                        input logic [31:0] la, input logic [31:0] lwd, input logic done, input logic halt);
    fetch_req = fr; fetch_addr = fa; ld_req = lr; ld_we = lwe;
    ld_addr = la; ld_wdata = lwd; ld_done = done; ld_halt = halt;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < DW; i++) sram[i] = '0;
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst cpu_hold", cpu_hold, 1);
    check("rst fetch_stall", fetch_stall, 1);
    check("rst mem_en", mem_en, 0);
    check("rst fetch_valid", fetch_valid, 0);
    reset = 1'b0;
    tick;
    // boot load
    set_in(0, 0, 1, 1, 32'h0, 32'hDEADBEEF, 0, 0); #2;
    check("boot gnt0", ld_gnt, 1);
    tick;
    set_in(0, 0, 1, 1, 32'h4, 32'h00000013, 0, 0); #2;
    check("boot gnt1", ld_gnt, 1);
    tick;
    set_in(0, 0, 0, 0, 0, 0, 1, 0); #2;
    check("boot hold before done", cpu_hold, 1);
    tick;
    check("boot hold released", cpu_hold, 0);
    set_in(1, 32'h4, 0, 0, 0, 0, 0, 0); #2;
    check("first fetch stall", fetch_stall, 0);
    check("first fetch addr", mem_addr, 1);
    tick;
    check("first fetch valid", fetch_valid, 1);
    check("first fetch data", fetch_data, 32'h00000013);
    // starvation: loader wins the 9th cycle
    set_in(1, 32'h4, 1, 0, 32'h0, 0, 0, 0);
    for (int i = 1; i <= 9; i++) begin
      #2;
      check("starve ld_gnt", ld_gnt, i == 9);
      check("starve fetch_stall", fetch_stall, i == 9);
      tick;
    end
    check("starve rvalid", ld_rvalid, 1);
    check("starve rdata", ld_rdata, 32'hDEADBEEF);
    #2;
    check("after starve fetch", fetch_stall, 0);
    tick;
    // idle slot
    set_in(0, 0, 1, 0, 32'h0, 0, 0, 0); #2;
    check("idle ld_gnt", ld_gnt, 1);
    check("idle fetch_stall", fetch_stall, 0);
    tick;
    set_in(1, 32'h0, 1, 0, 32'h0, 0, 0, 0); #2;
    check("cleared counter fetch wins", ld_gnt, 0);
    tick;
    // halt with a fetch read outstanding
    set_in(1, 32'h0, 0, 0, 0, 0, 0, 1); #2;
    check("halt stall", fetch_stall, 1);
    check("halt no access", mem_en, 0);
    check("halt fetch return", fetch_valid, 1);
    check("halt fetch data", fetch_data, 32'hDEADBEEF);
    tick;
    set_in(1, 32'h0, 0, 0, 0, 0, 0, 0); #2;
    check("drain stall", fetch_stall, 1);
    tick;
    check("reload hold", cpu_hold, 1);
    // wrap: 0x1000 aliases word 0
    set_in(1, 32'h0, 1, 1, 32'h1000, 32'hCAFEF00D, 0, 0); #2;
    check("wrap gnt", ld_gnt, 1);
    check("wrap addr", mem_addr, 0);
    check("load fetch stall", fetch_stall, 1);
    tick;
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    tick;
    set_in(1, 32'h0, 0, 0, 0, 0, 0, 0);
    tick;
    check("wrap fetch valid", fetch_valid, 1);
    check("wrap fetch data", fetch_data, 32'hCAFEF00D);
    check("ld_rdata held", ld_rdata, 32'hDEADBEEF);
    // reset during a granted read
    set_in(1, 32'h4, 0, 0, 0, 0, 0, 0);
    tick;
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("mid-read rst valid", fetch_valid, 0);
    check("mid-read rst data", fetch_data, 0);
    check("mid-read rst ld_rdata", ld_rdata, 0);
    check("mid-read rst hold", cpu_hold, 1);
    check("mid-read rst stall", fetch_stall, 1);
    tick;
    tick;
    check("post rst valid", fetch_valid, 0);
    reset = 1'b0;
    tick;
    tick;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
